// File: rtl/ui_iter_muldiv.sv
// ui_iter_muldiv: iterative unsigned multiply (shift-add) and restoring divide,
// one result bit per clock, started by a rising edge of the CCU's start level.
module ui_iter_muldiv #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rst,
    input  logic              start,
    input  logic              op,
    input  logic [XLEN-1:0]   a_b,
    input  logic [XLEN-1:0]   b_b,
    output logic [2*XLEN-1:0] y_b,
    output logic              end_step,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(XLEN - 1);

    state_t            state, stateNext;
    logic [CNT_W-1:0]  cnt, cntNext;
    logic              startQ;
    logic              opQ, opNext;
    logic [XLEN-1:0]   aQ, aNext;
    logic [XLEN-1:0]   bQ, bNext;
    // hiQ/loQ: {hi, lo} for MULU, {rem, q} for DIVU
    logic [XLEN-1:0]   hiQ, hiNext;
    logic [XLEN-1:0]   loQ, loNext;
    logic [2*XLEN-1:0] yQ, yNext;
    logic              endQ, endNext;
    logic              busyQ, busyNext;

    logic              accept;
    logic [XLEN:0]     mulSum;
    logic [XLEN:0]     divT;
    logic              divGe;
    logic [XLEN-1:0]   divDiff;
    logic [XLEN-1:0]   stepHi, stepLo;

    // One iteration of the selected algorithm plus next-state/next-value logic
    always_comb begin
        accept  = start && !startQ && (state == IDLE || state == DONE);

        mulSum  = {1'b0, hiQ} + (loQ[0] ? {1'b0, aQ} : '0);
        divT    = {hiQ, loQ[XLEN-1]};
        divGe   = (divT >= {1'b0, bQ});
        divDiff = divT[XLEN-1:0] - bQ;

        if (opQ) begin
            stepHi = divGe ? divDiff : divT[XLEN-1:0];
            stepLo = {loQ[XLEN-2:0], divGe};
        end else begin
            stepHi = mulSum[XLEN:1];
            stepLo = {mulSum[0], loQ[XLEN-1:1]};
        end

        stateNext = state;
        cntNext   = cnt;
        opNext    = opQ;
        aNext     = aQ;
        bNext     = bQ;
        hiNext    = hiQ;
        loNext    = loQ;
        yNext     = yQ;
        endNext   = 1'b0;
        busyNext  = busyQ;

        case (state)
            IDLE, DONE: begin
                stateNext = IDLE;
                if (accept) begin
                    stateNext = CALC;
                    opNext    = op;
                    aNext     = a_b;
                    bNext     = b_b;
                    cntNext   = '0;
                    hiNext    = '0;
                    loNext    = op ? a_b : b_b;
                    busyNext  = 1'b1;
                end
            end
            CALC: begin
                hiNext  = stepHi;
                loNext  = stepLo;
                cntNext = cnt + 1'b1;
                if (cnt == LAST_STEP) begin
                    stateNext = DONE;
                    yNext     = {stepHi, stepLo};
                    endNext   = 1'b1;
                    busyNext  = 1'b0;
                end
            end
            default: stateNext = IDLE;
        endcase
    end

    // State and working registers; async reset and sync clear give identical zero state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            startQ <= 1'b0;
            opQ    <= 1'b0;
            aQ     <= '0;
            bQ     <= '0;
            hiQ    <= '0;
            loQ    <= '0;
            yQ     <= '0;
            endQ   <= 1'b0;
            busyQ  <= 1'b0;
        end else if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            startQ <= 1'b0;
            opQ    <= 1'b0;
            aQ     <= '0;
            bQ     <= '0;
            hiQ    <= '0;
            loQ    <= '0;
            yQ     <= '0;
            endQ   <= 1'b0;
            busyQ  <= 1'b0;
        end else begin
            state  <= stateNext;
            cnt    <= cntNext;
            startQ <= start;
            opQ    <= opNext;
            aQ     <= aNext;
            bQ     <= bNext;
            hiQ    <= hiNext;
            loQ    <= loNext;
            yQ     <= yNext;
            endQ   <= endNext;
            busyQ  <= busyNext;
        end
    end

    assign y_b      = yQ;
    assign end_step = endQ;
    assign busy     = busyQ;

endmodule

// File: tb/tb_ui_iter_muldiv.sv
// tb_ui_iter_muldiv: vector table, randomized ops against an arithmetic model,
// and hand-written sequences for held start, back-to-back and aborts.
module tb_ui_iter_muldiv;

    localparam int XLEN = 32;

    logic              clk;
    logic              rst_n;
    logic              rst;
    logic              start;
    logic              op;
    logic [XLEN-1:0]   aIn;
    logic [XLEN-1:0]   bIn;
    logic [2*XLEN-1:0] yB;
    logic              endStep;
    logic              busy;

    int nChecks;
    int nFail;

    ui_iter_muldiv #(.XLEN(XLEN), .CNT_W(6)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rst      (rst),
        .start    (start),
        .op       (op),
        .a_b      (aIn),
        .b_b      (bIn),
        .y_b      (yB),
        .end_step (endStep),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic            op;
        logic [31:0]     a;
        logic [31:0]     b;
        logic [63:0]     y;
    } vec_t;

    vec_t vecs[6];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nChecks++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic on the operands
    function automatic logic [63:0] model(input logic o, input logic [31:0] a, input logic [31:0] b);
        if (!o)
            return 64'(a) * 64'(b);
        else if (b == 0)
            return {a, 32'hFFFF_FFFF};
        else
            return {a % b, a / b};
    endfunction

    // One complete operation with timing checks; operand buses are scrambled mid-run
    task automatic runOp(input logic o, input logic [31:0] a, input logic [31:0] b,
                         output logic [63:0] y);
        int edges;
        int busyCnt;
        @(negedge clk);
        op = o; aIn = a; bIn = b; start = 1'b1;
        @(posedge clk); #1;
        edges = 1;
        busyCnt = busy ? 1 : 0;
        check("busy_at_accept", 64'(busy), 64'd1);
        @(negedge clk);
        start = 1'b0; aIn = $urandom; bIn = $urandom; op = ~o;
        while (!endStep && edges < 100) begin
            @(posedge clk); #1;
            edges++;
            if (busy) busyCnt++;
        end
        check("edges_to_result", 64'(edges), 64'(XLEN + 1));
        check("busy_cycles", 64'(busyCnt), 64'(XLEN));
        y = yB;
        @(posedge clk); #1;
        check("end_step_falls", 64'(endStep), 64'd0);
        check("y_held", yB, y);
    endtask

    initial begin
        logic [63:0] y;
        logic [63:0] yFirst;
        logic        o;
        logic [31:0] a, b;
        int          t, tFirst, pulses;

        nChecks = 0;
        nFail   = 0;

        vecs[0] = '{1'b0, 32'd7,          32'd6,          64'h00000000_0000002A};
        vecs[1] = '{1'b0, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFFFFFE_00000001};
        vecs[2] = '{1'b0, 32'd0,          32'h1234_5678,  64'h00000000_00000000};
        vecs[3] = '{1'b1, 32'd100,        32'd7,          64'h00000002_0000000E};
        vecs[4] = '{1'b1, 32'd5,          32'd0,          64'h00000005_FFFFFFFF};
        vecs[5] = '{1'b1, 32'd3,          32'd10,         64'h00000003_00000000};

        rst_n = 1'b0; rst = 1'b1; start = 1'b0; op = 1'b0; aIn = '0; bIn = '0;
        #2;
        check("reset_y", yB, 64'd0);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_end", 64'(endStep), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Vector table
        for (int i = 0; i < 6; i++) begin
            runOp(vecs[i].op, vecs[i].a, vecs[i].b, y);
            check($sformatf("vec%0d_y", i), y, vecs[i].y);
        end

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            o = 1'($urandom_range(0, 1));
            a = $urandom;
            case (i % 4)
                0: b = $urandom;
                1: b = 32'($urandom_range(0, 15));
                2: b = a + 32'($urandom_range(0, 3));
                default: b = $urandom >> $urandom_range(0, 31);
            endcase
            runOp(o, a, b, y);
            check($sformatf("rand%0d_y", i), y, model(o, a, b));
        end

        // Start held high: exactly one operation
        @(negedge clk);
        op = 1'b1; aIn = 32'd9; bIn = 32'd3; start = 1'b1;
        pulses = 0;
        repeat (80) begin
            @(posedge clk); #1;
            if (endStep) pulses++;
        end
        check("held_pulses", 64'(pulses), 64'd1);
        check("held_y", yB, 64'h00000000_00000003);
        @(negedge clk); start = 1'b0;
        @(negedge clk);

        // Back-to-back: new start in the DONE cycle
        op = 1'b0; aIn = 32'd1000; bIn = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        t = 0;
        @(negedge clk); start = 1'b0;
        while (!endStep && t < 100) begin
            @(posedge clk); #1;
            t++;
        end
        tFirst = t;
        check("b2b_first_y", yB, 64'd3000);
        yFirst = yB;
        @(negedge clk);
        op = 1'b1; aIn = 32'd100; bIn = 32'd7; start = 1'b1;
        @(posedge clk); #1;
        t++;
        check("b2b_busy", 64'(busy), 64'd1);
        check("b2b_y_old", yB, yFirst);
        @(negedge clk); start = 1'b0;
        while (!endStep && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        check("b2b_spacing", 64'(t - tFirst), 64'(XLEN + 1));
        check("b2b_second_y", yB, 64'h00000002_0000000E);

        // Synchronous clear at iteration 10
        @(negedge clk);
        op = 1'b0; aIn = 32'd123; bIn = 32'd456; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        check("abort_busy", 64'(busy), 64'd0);
        check("abort_y", yB, 64'd0);
        @(negedge clk); rst = 1'b0;
        pulses = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (endStep) pulses++;
        end
        check("abort_no_end", 64'(pulses), 64'd0);

        // Asynchronous reset mid-CALC
        runOp(1'b0, 32'd11, 32'd13, y);
        check("pre_async_y", y, 64'd143);
        @(negedge clk);
        op = 1'b1; aIn = 32'd77; bIn = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        @(negedge clk); start = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("async_busy", 64'(busy), 64'd0);
        check("async_y", yB, 64'd0);
        check("async_end", 64'(endStep), 64'd0);
        @(negedge clk); rst_n = 1'b1;
        pulses = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (endStep) pulses++;
        end
        check("async_no_end", 64'(pulses), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule
